// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types, default latencies and lock-FSM encodings for
//               the decode/execute hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Default producer latencies: ALU results are forwardable next cycle,
    // load results one cycle later.
    localparam int c_ALU_LAT  = 1;
    localparam int c_LOAD_LAT = 2;
    localparam int c_TW       = 3;

    typedef logic [c_TW-1:0] hazard_lat_t;

    // Lock FSM encoding
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // Number of cycles a freshly written register must be held off
    // (a latency of L means the dependent may issue L cycles later).
    function automatic int lat_hold(input logic is_load, input int alu_lat,
                                    input int load_lat);
        return is_load ? (load_lat - 1) : (alu_lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_timer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_timer
// Description : Countdown timer for one architectural register. Counts down
//               to zero each cycle; a set request loads the larger of the
//               decremented value and the requested hold.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_timer
    import hazard_scoreboard_pkg::*;
#(
    parameter int TW = c_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set,
    input  logic [TW-1:0] i_hold,
    output logic [TW-1:0] o_timer,
    output logic          o_busy
);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_dec;
    logic [TW-1:0] w_next;

    // Decrement toward zero, then let a new producer extend the hold if longer
    always_comb begin
        w_dec  = (r_timer != '0) ? (r_timer - TW'(1)) : '0;
        w_next = w_dec;
        if (i_set && (i_hold > w_dec)) begin
            w_next = i_hold;
        end
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_next;
        end
    end

    assign o_timer = r_timer;
    assign o_busy  = (r_timer != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register countdown scoreboard deciding whether the decode
//               instruction may issue. Tracks variable producer latency, a
//               single outstanding control-flow lock and saturating stall
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int ALU_LAT  = c_ALU_LAT,
    parameter int LOAD_LAT = c_LOAD_LAT,
    parameter int TW       = c_TW,
    parameter int PERF_W   = 32,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rs1,
    input  logic              issue_rs1_en,
    input  logic [AW-1:0]     issue_rs2,
    input  logic              issue_rs2_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_wen,
    input  logic              issue_load,
    input  logic              issue_ctrl,
    input  logic              resolve_valid,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic              stall_data,
    output logic              stall_ctrl,
    output logic              lock,
    output logic              busy,
    output logic [PERF_W-1:0] data_stall_cnt,
    output logic [PERF_W-1:0] ctrl_stall_cnt
);

    localparam logic [TW-1:0] c_ALU_HOLD  = TW'(lat_hold(1'b0, ALU_LAT, LOAD_LAT));
    localparam logic [TW-1:0] c_LOAD_HOLD = TW'(lat_hold(1'b1, ALU_LAT, LOAD_LAT));

    logic [NREGS-1:0][TW-1:0] w_timer;
    logic [NREGS-1:0]         w_tbusy;
    logic                     w_set_en;
    logic [TW-1:0]            w_hold;
    logic                     w_hz1;
    logic                     w_hz2;
    logic [0:0]               r_state;
    logic [0:0]               w_state_next;
    logic [PERF_W-1:0]        r_data_cnt;
    logic [PERF_W-1:0]        r_ctrl_cnt;

    // x0 is hardwired and never tracked
    assign w_timer[0] = '0;
    assign w_tbusy[0] = 1'b0;

    assign w_set_en = issue_fire && issue_wen && (issue_rd != '0);
    assign w_hold   = issue_load ? c_LOAD_HOLD : c_ALU_HOLD;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_timer
            hazard_timer #(
                .TW (TW)
            ) u_timer (
                .clk     (clk),
                .rst     (reset),
                .i_set   (w_set_en && (issue_rd == AW'(gi))),
                .i_hold  (w_hold),
                .o_timer (w_timer[gi]),
                .o_busy  (w_tbusy[gi])
            );
        end
    endgenerate

    // Operand hazards: a read source whose producer is not yet forwardable
    assign w_hz1 = issue_rs1_en && (issue_rs1 != '0) && (w_timer[issue_rs1] != '0);
    assign w_hz2 = issue_rs2_en && (issue_rs2 != '0) && (w_timer[issue_rs2] != '0);

    assign stall_data = issue_valid && (w_hz1 || w_hz2);
    assign stall_ctrl = issue_valid && (lock || flush);
    assign stall      = stall_data || stall_ctrl;
    assign issue_fire = issue_valid && !stall;

    // Lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock next-state: a fired control instruction locks until resolved or flushed
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (issue_fire && issue_ctrl) begin
                    w_state_next = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                if (resolve_valid || flush) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign lock = (r_state == c_ST_LOCKED);
    assign busy = |w_tbusy;

    // Saturating stall-cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_cnt <= '0;
            r_ctrl_cnt <= '0;
        end else begin
            if (stall_data && (r_data_cnt != '1)) begin
                r_data_cnt <= r_data_cnt + PERF_W'(1);
            end
            if (stall_ctrl && (r_ctrl_cnt != '1)) begin
                r_ctrl_cnt <= r_ctrl_cnt + PERF_W'(1);
            end
        end
    end

    assign data_stall_cnt = r_data_cnt;
    assign ctrl_stall_cnt = r_ctrl_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. Instance a uses
//               default latencies; instance b uses ALU_LAT=3, LOAD_LAT=4 and
//               4-bit counters. Both share one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic       issue_rs1_en;
    logic [4:0] issue_rs2;
    logic       issue_rs2_en;
    logic [4:0] issue_rd;
    logic       issue_wen;
    logic       issue_load;
    logic       issue_ctrl;
    logic       resolve_valid;
    logic       flush;

    logic        a_stall, a_fire, a_sdata, a_sctrl, a_lock, a_busy;
    logic [31:0] a_dcnt, a_ccnt;
    logic        b_stall, b_fire, b_sdata, b_sctrl, b_lock, b_busy;
    logic [3:0]  b_dcnt, b_ccnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    hazard_scoreboard u_dut_a (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
        .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_load(issue_load),
        .issue_ctrl(issue_ctrl), .resolve_valid(resolve_valid), .flush(flush),
        .stall(a_stall), .issue_fire(a_fire), .stall_data(a_sdata),
        .stall_ctrl(a_sctrl), .lock(a_lock), .busy(a_busy),
        .data_stall_cnt(a_dcnt), .ctrl_stall_cnt(a_ccnt)
    );

    hazard_scoreboard #(
        .ALU_LAT(3), .LOAD_LAT(4), .PERF_W(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
        .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .issue_load(issue_load),
        .issue_ctrl(issue_ctrl), .resolve_valid(resolve_valid), .flush(flush),
        .stall(b_stall), .issue_fire(b_fire), .stall_data(b_sdata),
        .stall_ctrl(b_sctrl), .lock(b_lock), .busy(b_busy),
        .data_stall_cnt(b_dcnt), .ctrl_stall_cnt(b_ccnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        issue_valid   = 1'b0;
        issue_rs1     = '0;
        issue_rs1_en  = 1'b0;
        issue_rs2     = '0;
        issue_rs2_en  = 1'b0;
        issue_rd      = '0;
        issue_wen     = 1'b0;
        issue_load    = 1'b0;
        issue_ctrl    = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present one instruction, push its expected fire cycle, wait for the
    // selected instance to fire it, then pop and compare the fire cycle.
    task automatic issue_wait(input int sel, input logic [4:0] rs1, input logic rs1_en,
                              input logic [4:0] rs2, input logic rs2_en,
                              input logic [4:0] rd, input logic wen, input logic ld,
                              input logic ctl, input int exp_stalls, input string name,
                              output logic first_sd);
        int  fired_at;
        int  exp_at;
        bit  fired;
        fired    = 1'b0;
        fired_at = -1;
        first_sd = 1'b0;
        issue_valid  = 1'b1;
        issue_rs1    = rs1;
        issue_rs1_en = rs1_en;
        issue_rs2    = rs2;
        issue_rs2_en = rs2_en;
        issue_rd     = rd;
        issue_wen    = wen;
        issue_load   = ld;
        issue_ctrl   = ctl;
        exp_q.push_back(cyc + exp_stalls);
        for (int n = 0; n < 40 && !fired; n++) begin
            @(negedge clk);
            if (n == 0) first_sd = (sel == 0) ? a_sdata : b_sdata;
            if ((sel == 0) ? a_fire : b_fire) begin
                fired    = 1'b1;
                fired_at = cyc;
            end
            tick();
        end
        drive_idle();
        exp_at = exp_q.pop_front();
        checks++;
        if (!fired) begin
            errors++;
            $display("FAIL %s: no fire within bound, expected fire at cycle %0d", name, exp_at);
        end else if (fired_at != exp_at) begin
            errors++;
            $display("FAIL %s: fired at cycle %0d, expected %0d", name, fired_at, exp_at);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({a_stall, a_lock, a_busy, b_stall, b_lock, b_busy} !== 6'b0 ||
            a_dcnt !== 32'd0 || a_ccnt !== 32'd0 || b_dcnt !== 4'd0 || b_ccnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: a stall/lock/busy=%b%b%b cnt=%0d/%0d b=%b%b%b cnt=%0d/%0d, expected all 0",
                     a_stall, a_lock, a_busy, a_dcnt, a_ccnt, b_stall, b_lock, b_busy, b_dcnt, b_ccnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic sd;
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 0, "load_x5", sd);
        issue_wait(0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1, "use_x5", sd);
        checks++;
        if (sd !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall_data: got %b expected 1", sd);
        end
        @(negedge clk);
        checks++;
        if (a_dcnt !== 32'd1) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d expected 1", a_dcnt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic sd;
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 0, "alu_x3", sd);
        issue_wait(0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 0, "alu_b2b_1", sd);
        issue_wait(0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 0, "alu_b2b_2", sd);
        @(negedge clk);
        checks++;
        if (a_dcnt !== 32'd0) begin
            errors++;
            $display("FAIL alu_b2b_cnt: got %0d expected 0", a_dcnt);
        end
        tick();
        do_reset();
        issue_wait(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 0, "alu3_x3", sd);
        issue_wait(1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 2, "alu3_use", sd);
        @(negedge clk);
        checks++;
        if (b_dcnt !== 4'd2) begin
            errors++;
            $display("FAIL alu3_cnt: got %0d expected 2", b_dcnt);
        end
        tick();
    endtask

    task automatic test_x0();
        logic sd;
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 0, "load_x0", sd);
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: got %b expected 0", a_busy);
        end
        tick();
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 0, "load_x0_b", sd);
        issue_wait(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 0, "use_x0", sd);
    endtask

    task automatic test_branch_resolve();
        logic sd;
        int   exp_at;
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0, "branch", sd);
        issue_valid = 1'b1;
        exp_q.push_back(cyc + 4);
        for (int k = 1; k <= 4; k++) begin
            resolve_valid = (k == 4);
            @(negedge clk);
            checks++;
            if (a_sctrl !== 1'b1 || a_lock !== 1'b1 || a_fire !== 1'b0) begin
                errors++;
                $display("FAIL branch_lock_t%0d: stall_ctrl=%b lock=%b fire=%b expected 1 1 0",
                         k, a_sctrl, a_lock, a_fire);
            end
            tick();
        end
        resolve_valid = 1'b0;
        @(negedge clk);
        exp_at = exp_q.pop_front();
        checks++;
        if (a_fire !== 1'b1 || cyc != exp_at || a_lock !== 1'b0 || a_ccnt !== 32'd4) begin
            errors++;
            $display("FAIL branch_release: fire=%b cycle=%0d lock=%b cnt=%0d expected 1 %0d 0 4",
                     a_fire, cyc, a_lock, a_ccnt, exp_at);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_flush_timers();
        logic sd;
        int   exp_at;
        do_reset();
        issue_wait(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 0, "load_x7", sd);
        issue_wait(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0, "branch_b", sd);
        issue_valid  = 1'b1;
        issue_rs1    = 5'd7;
        issue_rs1_en = 1'b1;
        flush        = 1'b1;
        exp_q.push_back(cyc + 2);
        @(negedge clk);
        checks++;
        if (b_sctrl !== 1'b1 || b_sdata !== 1'b1 || b_lock !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: stall_ctrl=%b stall_data=%b lock=%b expected 1 1 1",
                     b_sctrl, b_sdata, b_lock);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (b_lock !== 1'b0 || b_sdata !== 1'b1 || b_sctrl !== 1'b0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: lock=%b stall_data=%b stall_ctrl=%b busy=%b expected 0 1 0 1",
                     b_lock, b_sdata, b_sctrl, b_busy);
        end
        tick();
        @(negedge clk);
        exp_at = exp_q.pop_front();
        checks++;
        if (b_fire !== 1'b1 || cyc != exp_at) begin
            errors++;
            $display("FAIL flush_x7_use: fire=%b cycle=%0d expected 1 %0d", b_fire, cyc, exp_at);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_reset_mid_stall();
        logic sd;
        do_reset();
        issue_wait(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 0, "load_x9", sd);
        issue_wait(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0, "branch_c", sd);
        issue_valid  = 1'b1;
        issue_rs1    = 5'd9;
        issue_rs1_en = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        checks++;
        if (b_stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b expected 1", b_stall);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (b_stall !== 1'b0 || b_lock !== 1'b0 || b_busy !== 1'b0 || b_fire !== 1'b1 ||
            b_dcnt !== 4'd0 || b_ccnt !== 4'd0 || a_lock !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: stall=%b lock=%b busy=%b fire=%b cnt=%0d/%0d a_lock=%b expected 0 0 0 1 0/0 0",
                     b_stall, b_lock, b_busy, b_fire, b_dcnt, b_ccnt, a_lock);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_saturate_and_idle_flush();
        logic sd;
        do_reset();
        issue_wait(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0, "branch_sat", sd);
        issue_valid = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        @(negedge clk);
        checks++;
        if (b_ccnt !== 4'hF || a_ccnt !== 32'd20 || b_dcnt !== 4'd0) begin
            errors++;
            $display("FAIL ctrl_cnt_saturate: b=%0d a=%0d b_data=%0d expected 15 20 0",
                     b_ccnt, a_ccnt, b_dcnt);
        end
        tick();
        resolve_valid = 1'b1;
        tick();
        do_reset();
        issue_valid = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        checks++;
        if (a_sctrl !== 1'b1 || a_fire !== 1'b0 || a_lock !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush: stall_ctrl=%b fire=%b lock=%b expected 1 0 0", a_sctrl, a_fire, a_lock);
        end
        tick();
        flush         = 1'b0;
        resolve_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_fire !== 1'b1 || a_lock !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_after: fire=%b lock=%b expected 1 0", a_fire, a_lock);
        end
        tick();
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_x0();
        test_branch_resolve();
        test_flush_timers();
        test_reset_mid_stall();
        test_saturate_and_idle_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed load/jump interlock: a per-register countdown scoreboard that decides cycle-by-cycle whether the instruction in decode may issue.
- Handles variable producer latency (ALU vs load), optional forwarding, and a single outstanding control-flow lock released by an explicit resolve or flush.
- Sits between decode and execute; drives the decode stall and carries saturating stall-cycle performance counters.

Parameters:
- NREGS, 32, architectural registers; index width AW = $clog2(NREGS); x0 is never tracked.
- ALU_LAT, 1, cycles from ALU producer issue to earliest dependent issue (1 = full forwarding; ≥1).
- LOAD_LAT, 2, same for loads (≥1, ≥ALU_LAT).
- TW, 3, timer width; must satisfy 2**TW > LOAD_LAT-1.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode holds a valid instruction
- issue_rs1  in  AW  source 1 index
- issue_rs1_en  in  1  source 1 is read
- issue_rs2  in  AW  source 2 index
- issue_rs2_en  in  1  source 2 is read
- issue_rd  in  AW  destination index
- issue_wen  in  1  instruction writes rd
- issue_load  in  1  instruction is a load
- issue_ctrl  in  1  instruction is JAL/JALR/BRANCH
- resolve_valid  in  1  execute has resolved the outstanding control instruction
- flush  in  1  redirect; decode content is wrong-path
- stall  out  1  decode must hold (combinational)
- issue_fire  out  1  issue_valid & ~stall
- stall_data  out  1  stall caused by a source-operand hazard
- stall_ctrl  out  1  stall caused by a control lock or flush
- lock  out  1  control instruction outstanding (registered)
- busy  out  1  any timer non-zero (registered)
- data_stall_cnt  out  PERF_W  saturating count of cycles with issue_valid & stall_data
- ctrl_stall_cnt  out  PERF_W  saturating count of cycles with issue_valid & stall_ctrl

Behaviour:
- Reset (synchronous): all timers 0; lock 0; both counters 0. Consequently stall=0, busy=0.
- State: timer[1..NREGS-1], TW bits each. A non-zero timer means the register's producer is not yet forwardable.
- Data hazard:
  - hz1 = issue_rs1_en & issue_rs1!=0 & timer[issue_rs1]!=0; hz2 is defined likewise.
  - stall_data = issue_valid & (hz1|hz2).
- Control stall: stall_ctrl = issue_valid & (lock | flush).
- Combined: stall = stall_data | stall_ctrl. All are combinational from registered state plus inputs.
- Timer update, every cycle:
  - every non-zero timer decrements by 1;
  - then, if issue_fire & issue_wen & issue_rd!=0, timer[issue_rd] <= max(decremented value, L-1), where L = issue_load ? LOAD_LAT : ALU_LAT.
  - The set wins over the decrement on the same register in the same cycle.
- Latency contract: a producer firing in cycle t lets a dependent fire no earlier than cycle t+L. With ALU_LAT=1, back-to-back dependents never stall.
- Lock FSM, states IDLE and LOCKED:
  - IDLE→LOCKED when issue_fire & issue_ctrl.
  - LOCKED→IDLE when resolve_valid or flush. issue is allowed from the next cycle.
  - resolve_valid in IDLE is ignored.
  - flush in IDLE has no state effect but stalls that cycle.
  - Because a control instruction cannot fire while LOCKED, a simultaneous fire and resolve cannot occur.
- flush does not clear timers, since older in-flight producers still write back.
- Counters: increment by 1 when their condition holds, saturate at all-ones.
- issue_rd=0 with issue_wen is legal and creates no scoreboard entry.

Decomposition:
- The rv32 package gains hazard_lat_t and the default constants ALU_LAT/LOAD_LAT.
- Sub-module hazard_timer: one instance per register holding the decrement/set/max logic, generated for indices 1..NREGS-1.
- The lock FSM and the counters stay in the top level.

Test Plan:
- Reset, then load x5 fires at t; add reading x5 valid from t+1 → stall_data=1 at t+1, fire at t+2, data_stall_cnt=1.
- ALU write x3 at t, consumer of x3 at t+1 → no stall, fire at t+1. Repeat with ALU_LAT=3 → fires at t+3.
- Load to x0, then a consumer of x0 → never stalls; busy stays 0.
- Branch fires at t; resolve_valid at t+4 → stall_ctrl=1 for t+1..t+4, next instruction fires t+5, lock cleared t+5, ctrl_stall_cnt=4.
- Branch fires, then flush at t+2 with an outstanding load timer on x7 → lock clears; x7 timer continues to count down; a consumer of x7 still honours LOAD_LAT.
- Assert reset mid-stall (timers and lock set) → next cycle stall=0, lock=0, busy=0, counters 0. Force PERF_W=4 with 20 stall cycles → counter holds 15.
